slave_serial_out_port: RTL and testbench

Transmit side of a serial-bus slave. Captures one parallel word from the slave core via a valid/ready handshake and shifts it MSB-first onto a single-bit line toward the master. The master gates each transfer with m_ready. Sits between the slave's internal data path and the physical serial bus.

---
 rtl/slave_serial_out_port.sv | 144 ++++++++++++++
 tb/tb_slave_serial_out_port.sv | 131 +++++++++++++
 2 files changed

// File: rtl/slave_serial_out_port.sv
// slave_serial_out_port
// Transmit side of a serial-bus slave. Accepts one parallel word from the
// slave core through a valid/ready handshake and shifts it MSB-first onto a
// single serial line toward the master. The master gates each frame with
// m_ready. Once a frame starts, it runs to completion regardless of the
// handshake inputs.
//
// Optional build macro: PARITY_EN. When defined, an even-parity bit (XOR of
// the word) follows the data bits, which delays DONE by one cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous reset, asserted HIGH despite the name
//   data_input  parallel word, sampled only on the start handshake
//   s_valid     slave core presents a valid word
//   m_ready     master ready to receive a frame
//   s_ready     port idle and able to accept a word (registered)
//   s_tx_done   one-cycle pulse after the last serial bit (registered)
//   tx_data     serial data line, idles high (registered)
//
// Requires DATA_WIDTH >= 2.
//
// state  | meaning
// IDLE   | line high, s_ready asserted, waiting for s_valid & m_ready
// SHIFT  | data bits on tx_data, MSB first, one per clock
// PARITY | even-parity bit on tx_data (PARITY_EN builds only)
// DONE   | line high, s_tx_done pulsed for this single cycle
module slave_serial_out_port #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_input,
    input  logic                  s_valid,
    input  logic                  m_ready,
    output logic                  s_ready,
    output logic                  s_tx_done,
    output logic                  tx_data
);

    localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DONE   = 2'd2
`ifdef PARITY_EN
        ,PARITY = 2'd3
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  s_ready_q, s_ready_d;
    logic                  done_q, done_d;
    logic                  tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            done_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            s_ready_q <= s_ready_d;
            done_q    <= done_d;
            tx_q      <= tx_d;
        end
    end

    // Outputs are registered, so each branch computes the value the outputs
    // must carry in the cycle after this edge.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        s_ready_d = 1'b0;
        done_d    = 1'b0;
        tx_d      = 1'b1;

        case (state_q)
            IDLE: begin
                s_ready_d = 1'b1;
                // Gating on s_ready_q keeps the first cycle after reset
                // (s_ready still low) from accepting a word nobody was
                // told could be taken.
                if (s_ready_q && s_valid && m_ready) begin
                    state_d   = SHIFT;
                    shreg_d   = data_input;
                    cnt_d     = '0;
                    tx_d      = data_input[DATA_WIDTH-1];
                    s_ready_d = 1'b0;
                end
            end

            SHIFT: begin
                if (cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                    // Rotation preserves the XOR of the word.
                    state_d = PARITY;
                    tx_d    = ^shreg_q;
`else
                    state_d = DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    // Rotate rather than shift so the word stays intact.
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], shreg_q[DATA_WIDTH-1]};
                    tx_d    = shreg_q[DATA_WIDTH-2];
                end
            end

`ifdef PARITY_EN
            PARITY: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`endif

            DONE: begin
                state_d   = IDLE;
                s_ready_d = 1'b1;
            end

            default: begin
                state_d   = IDLE;
                s_ready_d = 1'b1;
            end
        endcase
    end

    assign s_ready   = s_ready_q;
    assign s_tx_done = done_q;
    assign tx_data   = tx_q;

endmodule

// File: tb/tb_slave_serial_out_port.sv
// Testbench for slave_serial_out_port: directed scenarios followed by
// randomized traffic, all checked cycle by cycle against a frame-level model
// that queues the whole expected output sequence when a word is accepted.
module tb_slave_serial_out_port;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [DW-1:0] data_input = '0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_ready;
    logic          s_tx_done;
    logic          tx_data;

    slave_serial_out_port #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .data_input (data_input),
        .s_valid    (s_valid),
        .m_ready    (m_ready),
        .s_ready    (s_ready),
        .s_tx_done  (s_tx_done),
        .tx_data    (tx_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic tx;
        logic rdy;
        logic done;
    } out_t;

    out_t exp_q[$];
    out_t exp_now;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Frame-level reference: on an accepted start the entire remaining
    // output sequence of the frame is queued; otherwise the port is idle.
    task automatic model_edge(input logic rst, input logic v, input logic m, input logic [DW-1:0] d);
        if (rst) begin
            exp_q.delete();
            exp_now = '{tx: 1'b1, rdy: 1'b0, done: 1'b0};
            return;
        end
        if (exp_q.size() == 0 && exp_now.rdy && v && m) begin
            for (int i = DW - 1; i >= 0; i--)
                exp_q.push_back('{tx: d[i], rdy: 1'b0, done: 1'b0});
`ifdef PARITY_EN
            exp_q.push_back('{tx: ^d, rdy: 1'b0, done: 1'b0});
`endif
            exp_q.push_back('{tx: 1'b1, rdy: 1'b0, done: 1'b1});
        end
        if (exp_q.size() > 0)
            exp_now = exp_q.pop_front();
        else
            exp_now = '{tx: 1'b1, rdy: 1'b1, done: 1'b0};
    endtask

    task automatic cycle(input logic rst, input logic v, input logic m, input logic [DW-1:0] d);
        @(negedge clk);
        rstn       = rst;
        s_valid    = v;
        m_ready    = m;
        data_input = d;
        @(posedge clk);
        model_edge(rst, v, m, d);
        cyc++;
        #1;
        check("tx_data",   {31'd0, tx_data},   {31'd0, exp_now.tx});
        check("s_ready",   {31'd0, s_ready},   {31'd0, exp_now.rdy});
        check("s_tx_done", {31'd0, s_tx_done}, {31'd0, exp_now.done});
    endtask

    initial begin
        exp_now = '{tx: 1'b1, rdy: 1'b0, done: 1'b0};

        // Reset for two cycles, then release.
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Valid word but master not ready: must hold idle.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'hCC);

        // One frame of 0xCC, m_ready dropped right after the start.
        cycle(1'b0, 1'b1, 1'b1, 8'hCC);
        for (int i = 0; i < DW + 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'hCC);

        // Data and m_ready changing mid-frame must not disturb it.
        cycle(1'b0, 1'b1, 1'b1, 8'hCC);
        for (int i = 0; i < DW + 3; i++) cycle(1'b0, 1'b0, logic'(i[0]), 8'h00);

        // Back-to-back frames of 0xA5.
        for (int i = 0; i < 2 * (DW + 3) + 2; i++) cycle(1'b0, 1'b1, 1'b1, 8'hA5);
        for (int i = 0; i < DW + 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-frame, then a fresh frame.
        cycle(1'b0, 1'b1, 1'b1, 8'hCC);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'hCC);
        cycle(1'b1, 1'b0, 1'b0, 8'hCC);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < DW + 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(logic'($urandom_range(0, 79) == 0),
                  logic'($urandom_range(0, 3) != 0),
                  logic'($urandom_range(0, 1)),
                  DW'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
